// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential 6/3 restoring divider: state encoding,
// default widths and the iteration-counter sizing helper.
package seq_divider_pkg;

    localparam int DEF_N = 6;
    localparam int DEF_D = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ZERO = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counter must hold the value n itself, since it is loaded with n at accept.
    function automatic int iter_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when it fits.
module div_step #(
    parameter int D = 3
) (
    input  logic [D-1:0] p_i,
    input  logic         bit_i,
    input  logic [D-1:0] divisor_i,
    output logic [D-1:0] p_o,
    output logic         q_o
);

    logic [D:0] shifted;
    logic [D:0] divisor_ext;

    assign shifted     = {p_i, bit_i};
    assign divisor_ext = {1'b0, divisor_i};
    assign q_o         = (shifted >= divisor_ext);
    // After the conditional subtract the partial remainder is below the divisor,
    // so it always fits back into D bits.
    assign p_o         = D'(q_o ? (shifted - divisor_ext) : shifted);

endmodule

// File: rtl/seq_divider_6by3.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and registered results.
//
// state | meaning
// IDLE  | waiting for start, operands captured on the accepting edge
// RUN   | N restoring iterations, dividend MSB first
// ZERO  | divisor was zero, load the saturated result
// DONE  | done pulse for one cycle, results valid
module seq_divider_6by3
    import seq_divider_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int D = DEF_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [D-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = iter_cnt_w(N);

    state_e state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [D-1:0]  dsr_q, dsr_d;
    logic [D-1:0]  p_q, p_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [D-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [D-1:0]  step_p;
    logic          step_q;
    logic          last_iter;
    logic [N-1:0]  dvd_shift;

    div_step #(.D(D)) u_step (
        .p_i       (p_q),
        .bit_i     (dvd_q[N-1]),
        .divisor_i (dsr_q),
        .p_o       (step_p),
        .q_o       (step_q)
    );

    assign last_iter = (cnt_q == CW'(1));
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign dvd_shift = {dvd_q[N-2:0], step_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? ST_ZERO : ST_RUN;
                end
            end
            ST_RUN:  state_d = last_iter ? ST_DONE : ST_RUN;
            ST_ZERO: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        p_d         = p_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    p_d   = '0;
                    cnt_d = CW'(N);
                end
            end
            ST_RUN: begin
                dvd_d = dvd_shift;
                p_d   = step_p;
                cnt_d = cnt_q - CW'(1);
                if (last_iter) begin
                    quotient_d  = dvd_shift;
                    remainder_d = step_p;
                    dbz_d       = 1'b0;
                end
            end
            ST_ZERO: begin
                quotient_d  = '1;
                remainder_d = '0;
                dbz_d       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            p_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            p_q         <= p_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Self-checking bench for seq_divider_6by3: directed vector table, multiplier
// round-trip, random operands against an arithmetic model, and handshake corners.
module tb_seq_divider_6by3;

    localparam int N = 6;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [D-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_6by3 #(.N(N), .D(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dvd;
        int dsr;
        int q;
        int r;
        int z;
        int lat;
        int bsy;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero saturates.
    function automatic void ref_div(input int dvd, input int dsr,
                                    output int q, output int r, output int z);
        if (dsr == 0) begin
            q = (1 << N) - 1;
            r = 0;
            z = 1;
        end else begin
            q = dvd / dsr;
            r = dvd % dsr;
            z = 0;
        end
    endfunction

    // Issues one division from IDLE and observes it until busy drops again.
    // With interfere set, a second start and operand changes are driven mid-RUN.
    task automatic run_div(input int dvd, input int dsr, input bit interfere,
                           output int q, output int r, output int z,
                           output int lat, output int bcnt, output int dcnt);
        int n;
        bit seen;
        n = 0; seen = 0; lat = -1; bcnt = 0; dcnt = 0;
        q = -1; r = -1; z = -1;
        @(negedge clk);
        start    = 1'b1;
        dividend = N'(dvd);
        divisor  = D'(dsr);
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (interfere && n == 2) begin
                start    = 1'b1;
                dividend = N'(20);
                divisor  = D'(4);
            end
            if (interfere && n == 3) begin
                start    = 1'b0;
                dividend = N'(11);
                divisor  = D'(2);
            end
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (!seen) begin
                    lat = n - 1;
                    q   = int'(quotient);
                    r   = int'(remainder);
                    z   = int'(div_by_zero);
                end
                seen = 1'b1;
            end
            if (seen && !busy) break;
        end
        chk("done_seen", int'(seen), 1);
    endtask

    initial begin
        int q, r, z, lat, bcnt, dcnt;
        int eq, er, ez;
        int n, d1, d2;

        tbl[0] = '{42, 6,  7, 0, 0, 6, 7};
        tbl[1] = '{63, 5, 12, 3, 0, 6, 7};
        tbl[2] = '{ 5, 7,  0, 5, 0, 6, 7};
        tbl[3] = '{ 0, 3,  0, 0, 0, 6, 7};
        tbl[4] = '{49, 7,  7, 0, 0, 6, 7};
        tbl[5] = '{27, 0, 63, 0, 1, 1, 2};
        tbl[6] = '{27, 3,  9, 0, 0, 6, 7};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_div(tbl[i].dvd, tbl[i].dsr, 1'b0, q, r, z, lat, bcnt, dcnt);
            chk($sformatf("tbl%0d_quotient", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_remainder", i), r, tbl[i].r);
            chk($sformatf("tbl%0d_dbz", i), z, tbl[i].z);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busy_cycles", i), bcnt, tbl[i].bsy);
            chk($sformatf("tbl%0d_done_count", i), dcnt, 1);
        end

        for (int a = 0; a < 8; a++) begin
            for (int b = 1; b < 8; b++) begin
                run_div(a * b, b, 1'b0, q, r, z, lat, bcnt, dcnt);
                chk($sformatf("rt_%0dx%0d_quotient", a, b), q, a);
                chk($sformatf("rt_%0dx%0d_remainder", a, b), r, 0);
            end
        end

        for (int k = 0; k < 30; k++) begin
            int dv, ds;
            dv = int'($urandom_range(63, 0));
            ds = int'($urandom_range(7, 0));
            ref_div(dv, ds, eq, er, ez);
            run_div(dv, ds, 1'b0, q, r, z, lat, bcnt, dcnt);
            chk($sformatf("rnd_%0d/%0d_quotient", dv, ds), q, eq);
            chk($sformatf("rnd_%0d/%0d_remainder", dv, ds), r, er);
            chk($sformatf("rnd_%0d/%0d_dbz", dv, ds), z, ez);
            chk($sformatf("rnd_%0d/%0d_latency", dv, ds), lat, (ds == 0) ? 1 : N);
        end

        run_div(50, 7, 1'b1, q, r, z, lat, bcnt, dcnt);
        chk("busy_quotient", q, 7);
        chk("busy_remainder", r, 1);
        chk("busy_done_count", dcnt, 1);
        repeat (3) @(negedge clk);
        chk("busy_no_extra_busy", int'(busy), 0);

        @(negedge clk);
        start    = 1'b1;
        dividend = N'(42);
        divisor  = D'(6);
        n = 0; d1 = -1; d2 = -1;
        while (n < 40 && d2 < 0) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (d1 < 0) d1 = n;
                else d2 = n;
            end
        end
        start = 1'b0;
        chk("b2b_second_done", int'(d2 >= 0), 1);
        chk("b2b_period", d2 - d1, N + 2);
        chk("b2b_quotient", int'(quotient), 7);
        repeat (10) @(negedge clk);

        run_div(50, 7, 1'b0, q, r, z, lat, bcnt, dcnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = N'(60);
        divisor  = D'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_q_during_run", int'(quotient), 7);
        chk("hold_busy_during_run", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        run_div(30, 4, 1'b0, q, r, z, lat, bcnt, dcnt);
        chk("postrst_quotient", q, 7);
        chk("postrst_remainder", r, 2);
        chk("postrst_latency", lat, N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
